// File: rtl/img_bi_interp_pipe.sv
// Three-stage bilinear interpolator: a 2x2 neighbourhood and a fractional (row, col)
// offset go in, one Q(PIX_W).OUT_FRAC intensity comes out per cycle, with backpressure.
module img_bi_interp_pipe #(
    parameter int PIX_W     = 8,
    parameter int FRAC_BITS = 2,
    parameter int OUT_FRAC  = 4,
    parameter int ROUND_EN  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2*PIX_W-1:0]        row0_ele,
    input  logic [2*PIX_W-1:0]        row1_ele,
    input  logic [FRAC_BITS-1:0]      frac_r,
    input  logic [FRAC_BITS-1:0]      frac_c,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_W+OUT_FRAC-1:0] interp_I,
    output logic                      uniform
);

    localparam int W_W    = 2*FRAC_BITS + 1;
    localparam int P_W    = PIX_W + W_W;
    localparam int SUM_W  = P_W + 1;
    localparam int RES_W  = PIX_W + OUT_FRAC;
    localparam int D      = 2*FRAC_BITS - OUT_FRAC;
    localparam int SHR    = (D > 0) ? D : 0;
    localparam int SHL    = (D < 0) ? -D : 0;
    localparam int EXT_W  = SUM_W + SHL + 1;
    localparam int RND_SH = (SHR > 0) ? SHR - 1 : 0;
    localparam logic [EXT_W-1:0] RND_ADD =
        (ROUND_EN != 0 && SHR > 0) ? (EXT_W'(1) << RND_SH) : '0;
    localparam logic [FRAC_BITS:0] S_VAL = {1'b1, {FRAC_BITS{1'b0}}};

    function automatic logic [W_W-1:0] weight_mul(input logic [FRAC_BITS:0] a,
                                                  input logic [FRAC_BITS:0] b);
        logic [2*FRAC_BITS+1:0] p;
        p = {{(FRAC_BITS+1){1'b0}}, a} * {{(FRAC_BITS+1){1'b0}}, b};
        return p[W_W-1:0];
    endfunction

    function automatic logic [P_W-1:0] pix_mul(input logic [PIX_W-1:0] e,
                                               input logic [W_W-1:0]   w);
        return {{W_W{1'b0}}, e} * {{PIX_W{1'b0}}, w};
    endfunction

    logic                 advance_s;
    logic [FRAC_BITS:0]   x_s, y_s, sx_s, sy_s;
    logic [PIX_W-1:0]     e00_s, e01_s, e10_s, e11_s;
    logic                 eq_s;

    logic                 s1_valid_r, s1_eq_r;
    logic [PIX_W-1:0]     s1_e00_r, s1_e01_r, s1_e10_r, s1_e11_r;
    logic [W_W-1:0]       s1_w00_r, s1_w01_r, s1_w10_r, s1_w11_r;

    logic                 s2_valid_r, s2_eq_r;
    logic [PIX_W-1:0]     s2_e00_r;
    logic [P_W-1:0]       s2_p00_r, s2_p01_r, s2_p10_r, s2_p11_r;

    logic [SUM_W-1:0]     sum_s;
    logic [EXT_W-1:0]     scaled_s;
    logic [RES_W-1:0]     res_s;

    logic                 out_valid_r, uniform_r;
    logic [RES_W-1:0]     interp_i_r;

    // The whole pipe moves as one unit; the only combinational output path.
    assign advance_s = !out_valid_r || out_ready;
    assign in_ready  = advance_s;
    assign out_valid = out_valid_r;
    assign interp_I  = interp_i_r;
    assign uniform   = uniform_r;

    assign e00_s = row0_ele[2*PIX_W-1:PIX_W];
    assign e01_s = row0_ele[PIX_W-1:0];
    assign e10_s = row1_ele[2*PIX_W-1:PIX_W];
    assign e11_s = row1_ele[PIX_W-1:0];
    // Widened by one bit so S-x stays positive even at the largest fraction.
    assign x_s   = {1'b0, frac_r};
    assign y_s   = {1'b0, frac_c};
    assign sx_s  = S_VAL - x_s;
    assign sy_s  = S_VAL - y_s;
    assign eq_s  = (e00_s == e01_s) && (e01_s == e10_s) && (e10_s == e11_s);

    // Stage 1: capture pixels, bilinear weights and the uniform flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_eq_r    <= 1'b0;
            s1_e00_r   <= '0;
            s1_e01_r   <= '0;
            s1_e10_r   <= '0;
            s1_e11_r   <= '0;
            s1_w00_r   <= '0;
            s1_w01_r   <= '0;
            s1_w10_r   <= '0;
            s1_w11_r   <= '0;
        end else if (advance_s) begin
            s1_valid_r <= in_valid;
            s1_eq_r    <= eq_s;
            s1_e00_r   <= e00_s;
            s1_e01_r   <= e01_s;
            s1_e10_r   <= e10_s;
            s1_e11_r   <= e11_s;
            s1_w00_r   <= weight_mul(sx_s, sy_s);
            s1_w10_r   <= weight_mul(x_s, sy_s);
            s1_w01_r   <= weight_mul(sx_s, y_s);
            s1_w11_r   <= weight_mul(x_s, y_s);
        end
    end

    // Stage 2: the four pixel-weight products.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            s2_eq_r    <= 1'b0;
            s2_e00_r   <= '0;
            s2_p00_r   <= '0;
            s2_p01_r   <= '0;
            s2_p10_r   <= '0;
            s2_p11_r   <= '0;
        end else if (advance_s) begin
            s2_valid_r <= s1_valid_r;
            s2_eq_r    <= s1_eq_r;
            s2_e00_r   <= s1_e00_r;
            s2_p00_r   <= pix_mul(s1_e00_r, s1_w00_r);
            s2_p01_r   <= pix_mul(s1_e01_r, s1_w01_r);
            s2_p10_r   <= pix_mul(s1_e10_r, s1_w10_r);
            s2_p11_r   <= pix_mul(s1_e11_r, s1_w11_r);
        end
    end

    // Stage 3 datapath: sum, rescale to OUT_FRAC, saturate, uniform bypass.
    always_comb begin
        sum_s    = {1'b0, s2_p00_r} + {1'b0, s2_p01_r} + {1'b0, s2_p10_r} + {1'b0, s2_p11_r};
        scaled_s = ((EXT_W'(sum_s) + RND_ADD) >> SHR) << SHL;
        res_s    = '0;
        if (s2_eq_r) begin
            res_s = RES_W'(s2_e00_r) << OUT_FRAC;
        end else if (scaled_s[EXT_W-1:RES_W] != '0) begin
            res_s = '1;
        end else begin
            res_s = scaled_s[RES_W-1:0];
        end
    end

    // Stage 3 register: outputs only change on a real beat, so bubbles keep the last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            interp_i_r  <= '0;
            uniform_r   <= 1'b0;
        end else if (advance_s) begin
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                interp_i_r <= res_s;
                uniform_r  <= s2_eq_r;
            end
        end
    end

endmodule

// File: tb/tb_img_bi_interp_pipe.sv
// Scoreboard bench for img_bi_interp_pipe: default instance plus OUT_FRAC=2 truncating
// and rounding instances driven in lockstep from the same stimulus.
module tb_img_bi_interp_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] row0, row1;
    logic [1:0]  fr, fc;

    logic        in_ready, in_ready_t, in_ready_r;
    logic        out_valid, out_valid_t, out_valid_r;
    logic [11:0] interp_m;
    logic [9:0]  interp_t, interp_r;
    logic        uni_m, uni_t, uni_r;

    always #5 clk = ~clk;

    img_bi_interp_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .row0_ele(row0), .row1_ele(row1), .frac_r(fr), .frac_c(fc),
        .out_valid(out_valid), .out_ready(out_ready), .interp_I(interp_m), .uniform(uni_m));

    img_bi_interp_pipe #(.PIX_W(8), .FRAC_BITS(2), .OUT_FRAC(2), .ROUND_EN(0)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
        .row0_ele(row0), .row1_ele(row1), .frac_r(fr), .frac_c(fc),
        .out_valid(out_valid_t), .out_ready(out_ready), .interp_I(interp_t), .uniform(uni_t));

    img_bi_interp_pipe #(.PIX_W(8), .FRAC_BITS(2), .OUT_FRAC(2), .ROUND_EN(1)) dut_r (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_r),
        .row0_ele(row0), .row1_ele(row1), .frac_r(fr), .frac_c(fc),
        .out_valid(out_valid_r), .out_ready(out_ready), .interp_I(interp_r), .uniform(uni_r));

    typedef struct {
        int unsigned m;
        int unsigned t;
        int unsigned r;
        bit          u;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   n_out = 0;
    bit   hold_pending = 1'b0;
    int unsigned held_val;
    bit   trk = 1'b0;
    int   first_acc, first_ov, run;
    bit   run_done;
    bit   rand_rdy;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference bilinear interpolation with FRAC_BITS=2, PIX_W=8.
    function automatic int unsigned model(input int e00, e01, e10, e11, x, y, of, rnd);
        int s, sum, d, r, mx;
        s   = 4;
        sum = e00*(s-x)*(s-y) + e10*x*(s-y) + e01*(s-x)*y + e11*x*y;
        d   = 4 - of;
        if (d <= 0)     r = sum << (-d);
        else if (rnd)   r = (sum + (1 << (d-1))) >> d;
        else            r = sum >> d;
        mx = (256 << of) - 1;
        if (r > mx) r = mx;
        if (e00 == e01 && e01 == e10 && e10 == e11) r = e00 << of;
        return r;
    endfunction

    // em < 0 means use the model; otherwise em/et/er are the expected results.
    task automatic send(input int a, b, c, d, x, y, em, et, er);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        if (em < 0) begin
            e.m = model(a, b, c, d, x, y, 4, 0);
            e.t = model(a, b, c, d, x, y, 2, 0);
            e.r = model(a, b, c, d, x, y, 2, 1);
        end else begin
            e.m = em; e.t = et; e.r = er;
        end
        e.u = (a == b) && (b == c) && (c == d);
        in_valid = 1'b1;
        row0 = {a[7:0], b[7:0]};
        row1 = {c[7:0], d[7:0]};
        fr = x[1:0];
        fc = y[1:0];
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare on each output transfer, check stall stability.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            hold_pending = 1'b0;
        end else begin
            if (trk) begin
                if (in_valid) check("tput_in_ready", in_ready, 1);
                if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
                if (out_valid && first_ov < 0) first_ov = cyc;
                if (out_valid && !run_done) run++;
                else if (run > 0) run_done = 1'b1;
            end
            if (out_valid) begin
                if (hold_pending) check("stall_hold", interp_m, held_val);
                if (out_ready) begin
                    hold_pending = 1'b0;
                    if (sb.size() == 0) begin
                        check("unexpected_out", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        n_out++;
                        check("interp_main", interp_m, e.m);
                        check("interp_trunc", interp_t, e.t);
                        check("interp_round", interp_r, e.r);
                        check("uniform", uni_m, e.u);
                    end
                end else begin
                    hold_pending = 1'b1;
                    held_val = interp_m;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, lat;
        bit seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        row0 = 16'd0; row1 = 16'd0; fr = 2'd0; fc = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_interp", interp_m, 0);
        check("rst_uniform", uni_m, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Directed beats: {e00,e01,e10,e11}, x, y, main/trunc/round expectations.
        send(10, 20, 30, 40, 1, 2, 320, 80, 80);
        send(10, 20, 30, 40, 0, 0, 160, 40, 40);
        send(255, 255, 255, 255, 3, 3, 4080, 1020, 1020);
        send(0, 0, 0, 1, 1, 2, 2, 0, 1);
        send(0, 0, 0, 255, 3, 3, 2295, 573, 574);
        send(255, 0, 0, 0, 3, 3, 255, 63, 64);
        send(7, 7, 7, 7, 1, 3, 112, 28, 28);
        drain();

        // Random stream under random backpressure.
        n0 = n_out;
        rand_rdy = 1'b1;
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    int a, b, c, d;
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    a = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                    c = $urandom_range(0, 255);
                    d = $urandom_range(0, 255);
                    if ($urandom_range(0, 4) == 0) begin b = a; c = a; d = a; end
                    send(a, b, c, d, $urandom_range(0, 3), $urandom_range(0, 3), -1, 0, 0);
                end
                rand_rdy = 1'b0;
            end
            begin
                while (rand_rdy) begin
                    @(posedge clk); #1;
                    if (rand_rdy) out_ready = $urandom_range(0, 1);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("random_count", n_out - n0, 20);

        // Full throughput with out_ready held high.
        first_acc = -1; first_ov = -1; run = 0; run_done = 1'b0;
        trk = 1'b1;
        for (int k = 0; k < 16; k++)
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3), -1, 0, 0);
        drain();
        trk = 1'b0;
        check("tput_latency", first_ov - first_acc, 3);
        check("tput_run", run, 16);

        // Reset with two beats in flight.
        send(50, 60, 70, 80, 2, 1, -1, 0, 0);
        send(90, 91, 92, 93, 3, 0, -1, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_interp", interp_m, 0);
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #1;
        send(12, 34, 56, 78, 1, 1, -1, 0, 0);
        lat = 1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else lat++;
        end
        check("post_rst_latency", lat, 3);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/img_bi_interp_pipe.md
Name: img_bi_interp_pipe

Overview:
- Pipelined, parametrised bilinear interpolator for the pyramidal LK datapath. Serves image-1 sampling and image-2 warped sampling at arbitrary fractional precision.
- Accepts a 2x2 pixel neighbourhood and a fractional (row, col) offset on a valid/ready stream. Produces one interpolated intensity per cycle, in fixed-point format Q(PIX_W).OUT_FRAC.
- Adds what the single-cycle combinational interpolator lacks: pipelining, backpressure, optional rounding, saturation and a uniform-neighbourhood fast path.

Parameters:
- PIX_W, 8, pixel intensity width (unsigned).
- FRAC_BITS, 2, fractional bits of frac_r / frac_c.
- OUT_FRAC, 4, fractional bits of interp_I.
- ROUND_EN, 0, 0 = truncate when reducing fraction; 1 = round half-up.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat.
- row0_ele  in  2*PIX_W  {ele00, ele01}; ele00 in the MSBs.
- row1_ele  in  2*PIX_W  {ele10, ele11}.
- frac_r  in  FRAC_BITS  row fraction x, unsigned, value frac_r/2^FRAC_BITS.
- frac_c  in  FRAC_BITS  col fraction y, unsigned.
- out_valid  out  1  interp_I valid.
- out_ready  in  1  downstream accepts the output.
- interp_I  out  PIX_W+OUT_FRAC  interpolated intensity, Q(PIX_W).OUT_FRAC, unsigned.
- uniform  out  1  all four pixels were equal (qualified by out_valid).

Behaviour:
- Reset: out_valid=0, interp_I=0, uniform=0. All stage valid bits cleared. in_ready=1 in the cycle after rst deasserts.
- Reset mid-operation: all in-flight beats are discarded, with no partial output.
- Pipeline, 3 register stages, latency 3 cycles from input acceptance to out_valid, assuming no stall. Throughput is 1 beat per clock.
- Stage 1, captured:
  - the four pixels;
  - S=2^FRAC_BITS;
  - w00=(S-x)(S-y), w10=x(S-y), w01=(S-x)y, w11=xy, each 2*FRAC_BITS+1 bits wide;
  - eq flag = (ele00==ele01==ele10==ele11).
- Stage 2: the four products ele*w, each PIX_W+2*FRAC_BITS+1 bits wide.
- Stage 3:
  - sum = sum of the four products, width PIX_W+2*FRAC_BITS+2, which is lossless.
  - Let D = 2*FRAC_BITS - OUT_FRAC.
  - If D<=0: result = sum << -D.
  - If D>0 and ROUND_EN=0: result = sum >> D.
  - If D>0 and ROUND_EN=1: result = (sum + 2^(D-1)) >> D.
  - Saturate to all-ones of PIX_W+OUT_FRAC bits on overflow.
  - If eq: interp_I = ele00 << OUT_FRAC exactly, regardless of fraction or rounding.
  - uniform = eq.
- Weights always sum to S^2, so the result never exceeds max_pixel << OUT_FRAC. Saturation is defensive only.
- Handshake:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - All stages shift together when advance=1 and hold otherwise.
  - A beat is accepted when in_valid && in_ready.
  - While out_valid=1 && out_ready=0: interp_I and uniform are held stable and no beat is lost or duplicated.
- Bubbles: when in_valid=0 and advance=1, a bubble enters. Stage valid bits propagate the bubble and it never produces out_valid.
- Simultaneous accept and output in one cycle is allowed. Full throughput is required with out_ready held high.
- frac_r=frac_c=0 gives ele00 exactly. The maximum fraction (S-1) is valid and must not wrap the S-x terms.
- Purely combinational paths: in_ready only, from out_valid and out_ready.

Test Plan:
- Defaults, row0={10,20}, row1={30,40}, frac_r=1, frac_c=2 -> after 3 cycles out_valid=1, interp_I=320 (20.0), uniform=0.
- Defaults, same pixels, frac_r=0, frac_c=0 -> interp_I=160. Then all pixels 255, frac 3/3 -> interp_I=0xFF0, uniform=1.
- FRAC_BITS=2, OUT_FRAC=2, row0={0,0}, row1={0,1}, frac_r=1, frac_c=2 -> ROUND_EN=0 gives interp_I=0; ROUND_EN=1 gives interp_I=1.
- Stream 20 random beats with out_ready toggled pseudo-randomly -> outputs match the reference model in order, interp_I is stable while stalled, and the count equals 20.
- out_ready=1 and in_valid=1 continuously for 16 beats -> in_ready stays high and 16 consecutive out_valid cycles begin at cycle 3.
- Two beats in flight, assert rst for 1 cycle -> out_valid=0 next cycle, no stale output appears afterwards, and the next accepted beat emerges 3 cycles later.
